// File: rtl/vga_timing_ctrl_if.sv
// Raster timing bundle between the VGA timing controller and its consumers.
interface vga_timing_ctrl_if;
    localparam int unsigned CW = 10;

    logic          en;
    logic          pix_tick;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;
    logic          busy;

    // Timing generator: takes the run request, drives the raster.
    modport master (
        input  en,
        output pix_tick, hsync, vsync, video_on, x, y,
        output line_start, frame_start, busy
    );

    // Host / pixel-colour side: requests running, consumes the raster.
    modport slave (
        output en,
        input  pix_tick, hsync, vsync, video_on, x, y,
        input  line_start, frame_start, busy
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: pixel strobe every DIV clocks, h/v counters, sync and
// active-video decode, with start/stop that only ever stops on a frame boundary.
module vga_timing_ctrl #(
    parameter int unsigned DIV      = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned SYNC_POL = 0
) (
    input  logic               clk,
    input  logic               rst,
    vga_timing_ctrl_if.master  vga
);
    localparam int unsigned DW      = 4;
    localparam int unsigned CW      = 10;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic          SYNC_ACT = 1'(SYNC_POL);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RUN       = 2'd1,
        S_STOP_PEND = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;

    logic          tick_c;
    logic          frame_end_c;
    logic          run_c;
    logic          pix_tick_c;
    logic          video_on_c;
    logic          hsync_c;
    logic          vsync_c;
    logic          line_start_c;
    logic          frame_start_c;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, next counter values and the decode of those next values.
    always_comb begin
        state_d       = state_q;
        div_d         = '0;
        h_d           = '0;
        v_d           = '0;
        tick_c        = (state_q != S_IDLE) && (div_q == DIV_LAST);
        frame_end_c   = tick_c && (h_q == H_LAST) && (v_q == V_LAST);

        unique case (state_q)
            S_IDLE:      if (vga.en) state_d = S_RUN;
            S_RUN:       if (!vga.en) state_d = S_STOP_PEND;
            S_STOP_PEND: begin
                if (vga.en) begin
                    state_d = S_RUN;
                end else if (frame_end_c) begin
                    state_d = S_IDLE;
                end
            end
            default:     state_d = S_IDLE;
        endcase

        // Counters advance only while running; entering or leaving IDLE zeroes them.
        if ((state_q != S_IDLE) && (state_d != S_IDLE)) begin
            div_d = tick_c ? '0 : div_q + 1'b1;
            h_d   = h_q;
            v_d   = v_q;
            if (tick_c) begin
                if (h_q == H_LAST) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
        end

        run_c         = (state_d != S_IDLE);
        pix_tick_c    = run_c && (div_d == DIV_LAST);
        video_on_c    = run_c && (h_d < H_ACT) && (v_d < V_ACT);
        hsync_c       = (run_c && (h_d >= HS_BEG) && (h_d <= HS_END)) ? SYNC_ACT : ~SYNC_ACT;
        vsync_c       = (run_c && (v_d >= VS_BEG) && (v_d <= VS_END)) ? SYNC_ACT : ~SYNC_ACT;
        line_start_c  = run_c && (h_d == '0) && ((state_q == S_IDLE) || tick_c);
        frame_start_c = line_start_c && (v_d == '0);
    end

    // Counters and registered raster outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q           <= '0;
            h_q             <= '0;
            v_q             <= '0;
            vga.pix_tick    <= 1'b0;
            vga.hsync       <= ~SYNC_ACT;
            vga.vsync       <= ~SYNC_ACT;
            vga.video_on    <= 1'b0;
            vga.x           <= '0;
            vga.y           <= '0;
            vga.line_start  <= 1'b0;
            vga.frame_start <= 1'b0;
            vga.busy        <= 1'b0;
        end else begin
            div_q           <= div_d;
            h_q             <= h_d;
            v_q             <= v_d;
            vga.pix_tick    <= pix_tick_c;
            vga.hsync       <= hsync_c;
            vga.vsync       <= vsync_c;
            vga.video_on    <= video_on_c;
            vga.x           <= video_on_c ? h_d : '0;
            vga.y           <= video_on_c ? v_d : '0;
            vga.line_start  <= line_start_c;
            vga.frame_start <= frame_start_c;
            vga.busy        <= run_c;
        end
    end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl on a shrunken raster; a frame-position model is
// compared against every output each cycle, plus literal timing pins.
module tb_vga_timing_ctrl;
    localparam int DIV = 3;
    localparam int HA = 10, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
    localparam int SP = 0;
    localparam int HT = HA + HF + HS + HB;   // 17
    localparam int VT = VA + VF + VS + VB;   // 11
    localparam int LINE  = HT * DIV;         // 51
    localparam int FRAME = LINE * VT;        // 561
    localparam int MI = 0, MR = 1, MP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_timing_ctrl_if vif ();

    vga_timing_ctrl #(
        .DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(SP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vga (vif)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: run mode plus clock position within the current frame.
    int m_mode = MI;
    int m_t    = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = MI;
            m_t    = 0;
        end else begin
            case (m_mode)
                MI: if (vif.en) begin m_mode = MR; m_t = 0; end
                MR: begin
                    m_t = (m_t + 1) % FRAME;
                    if (!vif.en) m_mode = MP;
                end
                default: begin
                    if (vif.en) begin
                        m_mode = MR;
                        m_t = (m_t + 1) % FRAME;
                    end else if (m_t == FRAME - 1) begin
                        m_mode = MI;
                        m_t = 0;
                    end else begin
                        m_t = m_t + 1;
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            bit run;
            int p, h, v;
            logic e_vid, e_hs, e_vs;
            run   = (m_mode != MI);
            p     = m_t / DIV;
            h     = p % HT;
            v     = p / HT;
            e_vid = run && h < HA && v < VA;
            e_hs  = (run && h >= HA + HF && h < HA + HF + HS) ? 1'(SP) : ~1'(SP);
            e_vs  = (run && v >= VA + VF && v < VA + VF + VS) ? 1'(SP) : ~1'(SP);
            check("busy",        32'(vif.busy),        32'(run));
            check("pix_tick",    32'(vif.pix_tick),    32'(run && (m_t % DIV == DIV - 1)));
            check("video_on",    32'(vif.video_on),    32'(e_vid));
            check("x",           32'(vif.x),           e_vid ? 32'(h) : 32'd0);
            check("y",           32'(vif.y),           e_vid ? 32'(v) : 32'd0);
            check("hsync",       32'(vif.hsync),       32'(e_hs));
            check("vsync",       32'(vif.vsync),       32'(e_vs));
            check("line_start",  32'(vif.line_start),  32'(run && (m_t % LINE == 0)));
            check("frame_start", 32'(vif.frame_start), 32'(run && (m_t == 0)));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fs(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (vif.frame_start !== 1'b1 && n < limit);
        if (vif.frame_start !== 1'b1) n = -1;
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (vif.busy !== 1'b0 && n < limit);
        if (vif.busy !== 1'b0) n = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vif.en = 1'b0;
        rst    = 1'b1;
        cycles(3);
        chk_on = 1'b1;
        rst    = 1'b0;
        cycles(10);
        check("idle_busy",  32'(vif.busy),     32'd0);
        check("idle_hsync", 32'(vif.hsync),    32'd1);
        check("idle_vsync", 32'(vif.vsync),    32'd1);
        check("idle_video", 32'(vif.video_on), 32'd0);
        check("idle_tick",  32'(vif.pix_tick), 32'd0);

        // Start: offsets below are negedges after the first RUN edge.
        vif.en = 1'b1;
        cycles(1);
        check("start_fs",    32'(vif.frame_start), 32'd1);
        check("start_ls",    32'(vif.line_start),  32'd1);
        check("start_video", 32'(vif.video_on),    32'd1);
        check("start_busy",  32'(vif.busy),        32'd1);
        check("start_tick",  32'(vif.pix_tick),    32'd0);
        cycles(2);
        check("first_tick",  32'(vif.pix_tick),    32'd1);
        cycles(1);
        check("x_step1",     32'(vif.x),           32'd1);
        cycles(3);
        check("x_step2",     32'(vif.x),           32'd2);
        cycles(23);
        check("last_x",      32'(vif.x),           32'd9);
        cycles(1);
        check("video_fall",  32'(vif.video_on),    32'd0);
        cycles(5);
        check("hs_pre",      32'(vif.hsync),       32'd1);
        cycles(1);
        check("hs_on",       32'(vif.hsync),       32'd0);
        cycles(8);
        check("hs_last",     32'(vif.hsync),       32'd0);
        cycles(1);
        check("hs_off",      32'(vif.hsync),       32'd1);
        cycles(6);
        check("ls2",         32'(vif.line_start),  32'd1);
        check("ls2_y",       32'(vif.y),           32'd1);

        // Two full frames: frame_start period.
        wait_fs(FRAME + 10, n);
        wait_fs(FRAME + 10, n);
        check("fs_period", 32'(n), 32'(FRAME));

        // Stop request at line 3: finishes the frame, then idles.
        cycles(3 * LINE);
        vif.en = 1'b0;
        wait_idle(FRAME + 10, n);
        check("stop_len", 32'(n), 32'(FRAME - 3 * LINE));
        cycles(80);
        check("stopped_busy", 32'(vif.busy), 32'd0);

        // Stop at line 3, re-raise at line 7: no gap.
        vif.en = 1'b1;
        cycles(1);
        cycles(3 * LINE);
        vif.en = 1'b0;
        cycles(4 * LINE);
        vif.en = 1'b1;
        wait_fs(FRAME + 10, n);
        check("restart_period", 32'(n + 7 * LINE), 32'(FRAME));

        // Reset at line 5 with en held high.
        cycles(5 * LINE);
        rst = 1'b1;
        cycles(1);
        check("rst_busy",  32'(vif.busy),     32'd0);
        check("rst_video", 32'(vif.video_on), 32'd0);
        check("rst_hsync", 32'(vif.hsync),    32'd1);
        cycles(1);
        rst = 1'b0;
        cycles(1);
        check("post_rst_fs", 32'(vif.frame_start), 32'd1);

        // en falls on the frame-ending edge while running: new frame still runs.
        cycles(FRAME - 1);
        vif.en = 1'b0;
        cycles(1);
        check("edge_stop_fs",   32'(vif.frame_start), 32'd1);
        check("edge_stop_busy", 32'(vif.busy),        32'd1);
        wait_idle(FRAME + 10, n);
        check("edge_stop_len",  32'(n), 32'(FRAME));

        // en rises on the frame-ending edge while stop is pending.
        vif.en = 1'b1;
        cycles(5);
        vif.en = 1'b0;
        cycles(FRAME - 5);
        vif.en = 1'b1;
        cycles(1);
        check("edge_resume_fs",   32'(vif.frame_start), 32'd1);
        check("edge_resume_busy", 32'(vif.busy),        32'd1);

        // Randomised run control with occasional resets.
        for (int i = 0; i < 30; i++) begin
            vif.en = 1'($urandom_range(0, 1));
            cycles($urandom_range(1, 400));
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                cycles($urandom_range(1, 3));
                rst = 1'b0;
            end
        end
        vif.en = 1'b0;
        wait_idle(FRAME + 10, n);
        check("final_idle", 32'(n > 0), 32'd1);
        cycles(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

- Sequences the VGA raster from the 100 MHz system clock.
- Generates a one-cycle pixel strobe every DIV clocks (25 MHz at DIV=4); logic runs on that enable, not on a derived clock.
- Drives hsync/vsync, the active-video flag and pixel coordinates to the pixel-colour logic and the output pins.
- Start/stop run control ends only on frame boundaries, so the monitor never sees a truncated frame.

## Interface
- DIV, 4: system clocks per pixel; legal range 2..16.
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing in pixels.
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing in lines.
- SYNC_POL, 0: sync pulse polarity; 0 = active-low, 1 = active-high.
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  run request, level-sensitive.
- pix_tick  out  1  one-clk pixel strobe.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- video_on  out  1  current pixel lies in the active area.
- x  out  10  active column, 0..H_ACTIVE-1; 0 when video_on=0.
- y  out  10  active row, 0..V_ACTIVE-1; 0 when video_on=0.
- line_start  out  1  one-clk pulse on the first clk of each line (h=0).
- frame_start  out  1  one-clk pulse on the first clk of each frame (h=0, v=0).
- busy  out  1  high in RUN and STOP_PEND.

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤ 1024.
- Internal counters: div_cnt (4 bits), h_cnt and v_cnt (10 bits each). All wrap explicitly at their totals, never by overflow.
- FSM states:
  - IDLE: counters held at 0.
  - IDLE → RUN when en=1.
  - RUN → STOP_PEND when en=0.
  - STOP_PEND → RUN when en=1; raster continues uninterrupted.
  - STOP_PEND → IDLE on the tick that ends the frame (h=H_TOTAL-1, v=V_TOTAL-1); counters go to 0 and do not start a new frame.
- Entering RUN from IDLE clears div_cnt, h_cnt and v_cnt.
- pix_tick = 1 when div_cnt = DIV-1 in RUN or STOP_PEND. It is always 0 in IDLE.
- On a pix_tick edge:
  - h_cnt increments, or wraps to 0 at H_TOTAL-1.
  - On an h wrap, v_cnt increments, or wraps to 0 at V_TOTAL-1.
- Output decode (all outputs are registered):
  - Decodes use the next counter values, so outputs change on the same edge as the counters and hold for DIV clks per pixel.
  - video_on = h < H_ACTIVE && v < V_ACTIVE.
  - hsync is active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vsync is active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
  - "Active" means the level set by SYNC_POL.
- line_start / frame_start fire on the clk where the registered outputs first show h=0 (and v=0 for frame_start). This includes the first clk after IDLE → RUN.
- In IDLE: hsync/vsync inactive, video_on=0, x=y=0.
- Reset values: state IDLE, all counters 0, pix_tick=0, video_on=0, x=y=0, line_start=frame_start=0, busy=0; hsync=vsync=1 when SYNC_POL=0.
- Reset mid-frame: the next edge returns to IDLE values with no pending stop. If en=1 after reset, a fresh frame starts on the following clk.

## Timing
- Start latency:
  - Edge 1 (en sampled high in IDLE): state goes to RUN; outputs show (0,0), video_on=1, frame_start=1, line_start=1, busy=1.
  - First pix_tick occurs DIV-1 clks after that edge.
- Pixel period: DIV clks. Line: H_TOTAL·DIV = 3200 clks. Frame: H_TOTAL·V_TOTAL·DIV = 1,680,000 clks.
- With defaults:
  - hsync goes active 656·4 = 2624 clks after line_start and stays active 384 clks.
  - vsync goes active at line 490 and stays active 6400 clks.
- Stop latency: busy falls on the edge following the last pixel of the current frame, at most 1,680,000 clks after en falls.
- en changing on the same edge as the end-of-frame tick:
  - en=1 in STOP_PEND → RUN, next frame starts, frame_start pulses.
  - en=0 in RUN → STOP_PEND and the new frame runs to completion.

## Test plan
- Reset with en=0 → after 10 clks: busy=0, hsync=vsync=1, video_on=0, x=y=0, no pix_tick.
- en=1 from IDLE → frame_start and line_start pulse on the next clk. pix_tick repeats every 4 clks. x steps 0,1,2 every 4 clks. video_on falls after 2560 clks; hsync low for clks 2624..3007; next line_start at clk 3200.
- Run 2 full frames → frame_start period exactly 1,680,000 clks. vsync low exactly during lines 490–491. Exactly 480 video_on lines per frame.
- Drop en at line 100 → busy stays 1 until the frame ends, then 0. No further line_start; outputs hold IDLE values.
- Drop en at line 100, re-raise at line 300 → no gap; frame_start period unchanged.
- Assert rst at line 250 with en=1 → IDLE values on the next edge. A new frame_start appears one clk after rst is released.
